// File: rtl/xsr_rx_fifo.sv
// Serial receiver with edge-recentred bit sampler and a DEPTH-entry word FIFO.
// Frames of 1..DATA_W bits are assembled LSB- or MSB-first, right-justified.
module xsr_rx_fifo #(
   parameter int DATA_W    = 64,
   parameter int BAUD_W    = 32,
   parameter int DEPTH     = 8,
   parameter int MSB_FIRST = 0,
   localparam int BITS_W   = $clog2(DATA_W + 1),
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic [BITS_W-1:0] bits_i,
   input  logic [BAUD_W-1:0] baud_i,
   input  logic              rxd_i,
   input  logic              rxc_i,
   input  logic              ready_i,
   input  logic              clr_ovr_i,
   output logic [DATA_W-1:0] dat_o,
   output logic              valid_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              idle_o,
   output logic              sample_o,
   output logic              overrun_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic              d0, d1, c0, c1;
   logic              rx_edge;
   logic [BAUD_W-1:0] ctr;
   logic [BITS_W-1:0] bits_left;
   logic [BITS_W-1:0] frame_len;
   logic [BITS_W-1:0] bits_clamped;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_nxt;
   logic [DATA_W-1:0] word;
   logic              push;
   logic              pop;
   logic              full;
   logic              wr_en;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         d0 <= 1'b1;
         d1 <= 1'b1;
         c0 <= 1'b0;
         c1 <= 1'b0;
      end else begin
         d0 <= rxd_i;
         d1 <= d0;
         c0 <= rxc_i;
         c1 <= c0;
      end
   end

   assign rx_edge      = (d0 ^ d1) | (c0 & ~c1);
   assign idle_o       = (bits_left == '0);
   assign sample_o     = ~rx_edge & ~idle_o & (ctr == '0);
   assign push         = sample_o & (bits_left == BITS_W'(1));
   assign bits_clamped = (bits_i > BITS_W'(DATA_W)) ? BITS_W'(DATA_W) : bits_i;

   always_comb begin
      shreg_nxt = '0;
      word      = '0;
      if (MSB_FIRST != 0) begin
         shreg_nxt = {shreg[DATA_W-2:0], d0};
         word      = shreg_nxt;
      end else begin
         shreg_nxt = {d0, shreg[DATA_W-1:1]};
         word      = shreg_nxt >> (BITS_W'(DATA_W) - frame_len);
      end
   end

   // ctr is reloaded from baud_i on every idle cycle, so its reset value is never observed
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         ctr       <= '0;
         bits_left <= '0;
         frame_len <= '0;
         shreg     <= '0;
      end else if (rx_edge) begin
         if (idle_o) begin
            bits_left <= bits_clamped;
            frame_len <= bits_clamped;
            shreg     <= '0;
         end
         ctr <= baud_i >> 1;
      end else if (sample_o) begin
         ctr       <= baud_i;
         bits_left <= bits_left - BITS_W'(1);
         shreg     <= shreg_nxt;
      end else if (idle_o) begin
         ctr <= baud_i;
      end else begin
         ctr <= ctr - BAUD_W'(1);
      end
   end

   assign valid_o = (count != '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign pop     = valid_o & ready_i;
   assign wr_en   = push & (~full | pop);
   assign count_o = count;
   assign dat_o   = valid_o ? mem[rd_ptr] : '0;

   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr] <= word;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overrun_o <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(wr_en);
         rd_ptr <= rd_ptr + PTR_W'(pop);
         unique case ({wr_en, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (push & full & ~pop) overrun_o <= 1'b1;
         else if (clr_ovr_i)     overrun_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_xsr_rx_fifo.sv
// Bench for xsr_rx_fifo: LSB-first and MSB-first instances share stimulus;
// expected words are queued per frame and checked by a pop monitor.
module tb_xsr_rx_fifo;

   localparam int DW    = 8;
   localparam int BW    = 16;
   localparam int DP    = 4;
   localparam int BITSW = 4;
   localparam int CNTW  = 3;

   logic             clk_i = 1'b0;
   logic             reset_ni = 1'b0;
   logic [BITSW-1:0] bits_i = 4'd8;
   logic [BW-1:0]    baud_i = 16'd9;
   logic             rxd_i = 1'b1;
   logic             rxc_i = 1'b0;
   logic             ready_i = 1'b0;
   logic             clr_ovr_i = 1'b0;

   logic [DW-1:0]    dat_l, dat_m;
   logic             valid_l, valid_m;
   logic [CNTW-1:0]  count_l, count_m;
   logic             idle_l, idle_m;
   logic             sample_l, sample_m;
   logic             overrun_l, overrun_m;

   xsr_rx_fifo #(.DATA_W(DW), .BAUD_W(BW), .DEPTH(DP), .MSB_FIRST(0)) u_lsb (
      .clk_i(clk_i), .reset_ni(reset_ni), .bits_i(bits_i), .baud_i(baud_i),
      .rxd_i(rxd_i), .rxc_i(rxc_i), .ready_i(ready_i), .clr_ovr_i(clr_ovr_i),
      .dat_o(dat_l), .valid_o(valid_l), .count_o(count_l), .idle_o(idle_l),
      .sample_o(sample_l), .overrun_o(overrun_l));

   xsr_rx_fifo #(.DATA_W(DW), .BAUD_W(BW), .DEPTH(DP), .MSB_FIRST(1)) u_msb (
      .clk_i(clk_i), .reset_ni(reset_ni), .bits_i(bits_i), .baud_i(baud_i),
      .rxd_i(rxd_i), .rxc_i(rxc_i), .ready_i(ready_i), .clr_ovr_i(clr_ovr_i),
      .dat_o(dat_m), .valid_o(valid_m), .count_o(count_m), .idle_o(idle_m),
      .sample_o(sample_m), .overrun_o(overrun_m));

   always #5 clk_i = ~clk_i;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   logic [DW-1:0] q_l[$];
   logic [DW-1:0] q_m[$];

   int samp_cnt  = 0;
   int busy_cnt  = 0;
   int gap_bad   = 0;
   int prev_samp = -1;
   int gap_exp   = 10;
   bit gap_en    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [DW-1:0] rev(input logic [DW-1:0] v, input int n);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r[n-1-i] = v[i];
      return r;
   endfunction

   always @(posedge clk_i) cyc++;

   always @(negedge clk_i) begin
      if (sample_l) begin
         if (gap_en && prev_samp >= 0 && (cyc - prev_samp) != gap_exp) gap_bad++;
         prev_samp = cyc;
         samp_cnt++;
      end
      if (!idle_l) busy_cnt++;
   end

   // pop monitor: a handshake seen here completes at the next rising edge
   always @(negedge clk_i) begin
      if (reset_ni && ready_i && (valid_l || valid_m)) begin
         check("valid_match", valid_m, valid_l);
         if (q_l.size() == 0 || q_m.size() == 0) begin
            total++;
            $display("FAIL pop_unexpected: got lsb %0h msb %0h expected no word", dat_l, dat_m);
         end else begin
            check("pop_lsb", dat_l, q_l.pop_front());
            check("pop_msb", dat_m, q_m.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send_frame(input logic [DW-1:0] v, input int nsend, input logic [BITSW-1:0] bits,
                             input logic [BW-1:0] baud, input bit accept, input bit pop_at_push);
      int            n_eff;
      logic [DW-1:0] mask;
      n_eff  = (int'(bits) > DW) ? DW : int'(bits);
      mask   = DW'((9'h1 << n_eff) - 9'h1);
      bits_i = bits;
      baud_i = baud;
      if (accept) begin
         q_l.push_back(v & mask);
         q_m.push_back(rev(v, n_eff));
      end
      for (int i = 0; i < nsend; i++) begin
         rxd_i = v[i];
         rxc_i = (i == 0);
         for (int j = 0; j <= int'(baud); j++) begin
            tick();
            rxc_i = 1'b0;
            if (pop_at_push) ready_i = (i == nsend - 1) && sample_l;
         end
      end
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dat"},     dat_l,     32'h0);
      check({tag, "_valid"},   valid_l,   32'h0);
      check({tag, "_count"},   count_l,   32'h0);
      check({tag, "_idle"},    idle_l,    32'h1);
      check({tag, "_sample"},  sample_l,  32'h0);
      check({tag, "_overrun"}, overrun_l, 32'h0);
      check({tag, "_dat_m"},   dat_m,     32'h0);
   endtask

   initial begin
      int s0, b0;
      #3;
      check_reset_outputs("rst");
      repeat (2) tick();
      reset_ni = 1'b1;
      tick();

      // T1: 0xA5 LSB-first, baud 9
      gap_exp = 10; prev_samp = -1; gap_bad = 0; gap_en = 1'b1;
      s0 = samp_cnt;
      send_frame(8'hA5, 8, 4'd8, 16'd9, 1'b1, 1'b0);
      gap_en = 1'b0;
      check("t1_samples", samp_cnt - s0, 32'd8);
      check("t1_gap",     gap_bad,       32'd0);
      check("t1_valid",   valid_l,       32'h1);
      check("t1_dat",     dat_l,         32'hA5);
      check("t1_count",   count_l,       32'd1);
      check("t1_idle",    idle_l,        32'h1);
      ready_i = 1'b1; tick(); ready_i = 1'b0;
      check("t1_count_after_pop", count_l, 32'd0);
      check("t1_dat_empty",       dat_l,   32'h0);

      // T2: 5-bit frame 1,0,1,1,0 at baud 5
      send_frame(8'h0D, 5, 4'd5, 16'd5, 1'b1, 1'b0);
      check("t2_dat_lsb", dat_l, 32'h0D);
      check("t2_dat_msb", dat_m, 32'h16);
      ready_i = 1'b1; tick(); ready_i = 1'b0;

      // T3: overflow with ready low
      for (int k = 1; k <= 5; k++)
         send_frame(DW'(k * 8'h11), 8, 4'd8, 16'd9, k <= 4, 1'b0);
      check("t3_count",     count_l,   32'd4);
      check("t3_overrun",   overrun_l, 32'h1);
      check("t3_overrun_m", overrun_m, 32'h1);
      check("t3_dat_head",  dat_l,     32'h11);
      clr_ovr_i = 1'b1; tick(); clr_ovr_i = 1'b0;
      check("t3_overrun_clr", overrun_l, 32'h0);
      ready_i = 1'b1; repeat (4) tick(); ready_i = 1'b0;
      check("t3_drained", count_l, 32'd0);

      // T4: push into full FIFO while popping
      for (int k = 0; k < 4; k++)
         send_frame(DW'(8'h61 + k), 8, 4'd8, 16'd9, 1'b1, 1'b0);
      check("t4_full", count_l, 32'd4);
      send_frame(8'h65, 8, 4'd8, 16'd9, 1'b1, 1'b1);
      check("t4_count",   count_l,   32'd4);
      check("t4_overrun", overrun_l, 32'h0);
      ready_i = 1'b1; repeat (4) tick(); ready_i = 1'b0;
      check("t4_drained", count_l, 32'd0);

      // T5: reset in the middle of a frame, with a word already buffered
      send_frame(8'h5A, 8, 4'd8, 16'd9, 1'b0, 1'b0);
      bits_i = 4'd8; baud_i = 16'd9;
      for (int i = 0; i < 3; i++) begin
         rxd_i = i[0];
         rxc_i = (i == 0);
         for (int j = 0; j < 10; j++) begin tick(); rxc_i = 1'b0; end
      end
      rxd_i = 1'b1;
      repeat (3) tick();
      check("t5_busy_before_reset", idle_l, 32'h0);
      reset_ni = 1'b0;
      #2;
      check_reset_outputs("t5_rst");
      repeat (3) tick();
      reset_ni = 1'b1;
      tick();
      check("t5_idle_after_release", idle_l, 32'h1);
      send_frame(8'h3C, 8, 4'd8, 16'd9, 1'b1, 1'b0);
      check("t5_dat", dat_l, 32'h3C);
      ready_i = 1'b1; tick(); ready_i = 1'b0;

      // T6: zero-length and over-length frames
      s0 = samp_cnt; b0 = busy_cnt;
      bits_i = 4'd0;
      rxd_i = ~rxd_i; repeat (20) tick();
      rxd_i = ~rxd_i; rxc_i = 1'b1; tick(); rxc_i = 1'b0; repeat (20) tick();
      check("t6_zero_samples", samp_cnt - s0, 32'd0);
      check("t6_zero_busy",    busy_cnt - b0, 32'd0);
      check("t6_zero_count",   count_l,       32'd0);
      s0 = samp_cnt;
      send_frame(8'h96, 8, 4'd12, 16'd9, 1'b1, 1'b0);
      repeat (20) tick();
      check("t6_long_samples", samp_cnt - s0, 32'd8);
      check("t6_long_idle",    idle_l,        32'h1);
      check("t6_long_count",   count_l,       32'd1);
      ready_i = 1'b1; tick(); ready_i = 1'b0;
      tick();

      check("end_q_lsb", q_l.size(), 32'd0);
      check("end_q_msb", q_m.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
